// File: rtl/mem_access_unit_pkg.sv
// Shared encodings for the MEM-stage access unit: load types, FSM states,
// byte-enable patterns and the bus command payload.
package mem_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned BE_WIDTH = 4;
  localparam int unsigned LT_WIDTH = 3;

  localparam logic [LT_WIDTH-1:0] LT_NONE = 3'd0;
  localparam logic [LT_WIDTH-1:0] LB      = 3'd1;
  localparam logic [LT_WIDTH-1:0] LH      = 3'd2;
  localparam logic [LT_WIDTH-1:0] LW      = 3'd3;
  localparam logic [LT_WIDTH-1:0] LBU     = 3'd4;
  localparam logic [LT_WIDTH-1:0] LHU     = 3'd5;

  localparam logic [BE_WIDTH-1:0] BE_NONE = 4'b0000;
  localparam logic [BE_WIDTH-1:0] BE_BYTE = 4'b0001;
  localparam logic [BE_WIDTH-1:0] BE_HALF = 4'b0011;
  localparam logic [BE_WIDTH-1:0] BE_WORD = 4'b1111;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  typedef struct packed {
    logic [XLEN-1:0]     addr;
    logic [BE_WIDTH-1:0] we;
    logic [XLEN-1:0]     wdata;
  } bus_cmd_t;

  // Halfword accesses need bit 0 clear, word accesses need both low bits clear.
  function automatic logic is_misaligned(logic [1:0] off, logic [BE_WIDTH-1:0] be,
                                         logic is_load, logic [LT_WIDTH-1:0] lt);
    logic half;
    logic word;
    half = is_load ? ((lt == LH) || (lt == LHU)) : (be == BE_HALF);
    word = is_load ? (lt == LW) : (be == BE_WORD);
    return (half && off[0]) || (word && (off != 2'b00));
  endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// Single-outstanding memory bus between the access unit (master) and memory (slave).
interface mem_bus_if;
  import mem_pkg::*;

  logic                bus_req;
  logic [XLEN-1:0]     bus_addr;
  logic [BE_WIDTH-1:0] bus_we;
  logic [XLEN-1:0]     bus_wdata;
  logic                bus_gnt;
  logic                bus_rvalid;
  logic [XLEN-1:0]     bus_rdata;

  modport master (
    output bus_req, bus_addr, bus_we, bus_wdata,
    input  bus_gnt, bus_rvalid, bus_rdata
  );

  modport slave (
    input  bus_req, bus_addr, bus_we, bus_wdata,
    output bus_gnt, bus_rvalid, bus_rdata
  );
endinterface

// File: rtl/mem_access_unit_load_formatter.sv
// Aligns returned bus data to the access offset and sign/zero-extends it per load type.
module load_formatter
  import mem_pkg::*;
(
  input  logic [XLEN-1:0]     rdata,
  input  logic [1:0]          offset,
  input  logic [LT_WIDTH-1:0] ltype,
  output logic [XLEN-1:0]     data
);

  logic [XLEN-1:0] shifted;

  assign shifted = rdata >> {offset, 3'b000};

  always_comb begin
    data = shifted;
    case (ltype)
      LB:      data = {{24{shifted[7]}}, shifted[7:0]};
      LH:      data = {{16{shifted[15]}}, shifted[15:0]};
      LBU:     data = {24'd0, shifted[7:0]};
      LHU:     data = {16'd0, shifted[15:0]};
      default: data = shifted;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store sequencer: issues one bus access per instruction and stalls the pipe.
// Optional misaligned-access trap enabled by defining MEM_MISALIGN_TRAP_EN.
module mem_access_unit
  import mem_pkg::*;
(
  input  logic                clk,
  input  logic                rst_n,
  input  logic [XLEN-1:0]     AluOutM,
  input  logic [XLEN-1:0]     StoreDataM,
  input  logic [BE_WIDTH-1:0] MemWriteM,
  input  logic                MemToRegM,
  input  logic [LT_WIDTH-1:0] RegWriteM,
  output logic                MemStall,
  output logic [XLEN-1:0]     LoadDataM,
  output logic                LoadValidM,
  output logic                MisalignExc,
  mem_bus_if.master           bus
);

  state_t          state_q;
  state_t          state_d;
  bus_cmd_t        cmd;
  logic            pending;
  logic            trap_c;
  logic [1:0]      off;
  logic [XLEN-1:0] fmt_data;

  assign off     = AluOutM[1:0];
  assign pending = MemToRegM | (|MemWriteM);

`ifdef MEM_MISALIGN_TRAP_EN
  assign trap_c = is_misaligned(off, MemWriteM, MemToRegM, RegWriteM);
`else
  assign trap_c = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Next state; a trapped access skips the bus entirely.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (pending)        state_d = trap_c ? DONE : REQ;
      REQ:     if (bus.bus_gnt)    state_d = MemToRegM ? WAIT : DONE;
      WAIT:    if (bus.bus_rvalid) state_d = DONE;
      DONE:                        state_d = IDLE;
      default:                     state_d = IDLE;
    endcase
  end

  // Bus command and stall; write lanes are only driven while a store is requesting.
  always_comb begin
    bus.bus_req = 1'b0;
    cmd         = '0;
    cmd.addr    = {AluOutM[XLEN-1:2], 2'b00};
    MemStall    = pending && (state_q != DONE);
    if (state_q == REQ) begin
      bus.bus_req = 1'b1;
      if (!MemToRegM) begin
        cmd.we    = MemWriteM << off;
        cmd.wdata = StoreDataM << {off, 3'b000};
      end
    end
  end

  assign bus.bus_addr  = cmd.addr;
  assign bus.bus_we    = cmd.we;
  assign bus.bus_wdata = cmd.wdata;

  load_formatter u_fmt (
    .rdata  (bus.bus_rdata),
    .offset (off),
    .ltype  (RegWriteM),
    .data   (fmt_data)
  );

  // Load result is captured on the returning beat and held until the next load completes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      LoadDataM  <= '0;
      LoadValidM <= 1'b0;
    end else begin
      LoadValidM <= (state_q == WAIT) && bus.bus_rvalid;
      if ((state_q == WAIT) && bus.bus_rvalid) LoadDataM <= fmt_data;
    end
  end

`ifdef MEM_MISALIGN_TRAP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) MisalignExc <= 1'b0;
    else        MisalignExc <= (state_q == IDLE) && pending && trap_c;
  end
`else
  assign MisalignExc = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: directed table, hand sequences, random vs. model.
module tb_mem_access_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] AluOutM, StoreDataM, LoadDataM;
  logic [3:0]  MemWriteM;
  logic        MemToRegM, MemStall, LoadValidM, MisalignExc;
  logic [2:0]  RegWriteM;

  mem_bus_if bus ();

  mem_access_unit dut (
    .clk(clk), .rst_n(rst_n), .AluOutM(AluOutM), .StoreDataM(StoreDataM),
    .MemWriteM(MemWriteM), .MemToRegM(MemToRegM), .RegWriteM(RegWriteM),
    .MemStall(MemStall), .LoadDataM(LoadDataM), .LoadValidM(LoadValidM),
    .MisalignExc(MisalignExc), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] sdata;
    logic [3:0]  we;
    logic        ld;
    logic [2:0]  lt;
    int          gd;
    int          rd;
    logic [31:0] rdata;
    logic        spur;
    logic [31:0] e_addr;
    logic [3:0]  e_we;
    logic [31:0] e_wdata;
    logic [31:0] e_ld;
    int          e_stall;
  } vec_t;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_ld = 32'd0;

  int          o_stall, o_lv, o_exc, o_req;
  logic        o_done;
  logic [31:0] o_addr, o_wdata, o_ldata;
  logic [3:0]  o_we;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  function automatic longint pow256(input int n);
    longint p = 1;
    for (int i = 0; i < n; i++) p = p * 256;
    return p;
  endfunction

  // Reference: arithmetic view of byte lanes, independent of the RTL's shifters.
  function automatic logic [31:0] ref_load(input logic [31:0] rdata, input int off,
                                           input logic [2:0] lt);
    longint v = longint'(rdata) / pow256(off);
    longint b;
    case (lt)
      LB:  begin b = v % 256;   if (b >= 128)   b = b - 256;   end
      LH:  begin b = v % 65536; if (b >= 32768) b = b - 65536; end
      LBU: b = v % 256;
      LHU: b = v % 65536;
      default: b = v;
    endcase
    return 32'(b);
  endfunction

  function automatic logic [3:0] ref_we(input logic [3:0] we, input int off);
    return 4'((int'(we) * (1 << off)) % 16);
  endfunction

  function automatic logic [31:0] ref_wdata(input logic [31:0] d, input int off);
    return 32'((longint'(d) * pow256(off)) % (longint'(1) << 32));
  endfunction

  // One MEM-stage access with a responsive memory model; records what was observed.
  task automatic run(input vec_t v);
    int gnt_at = -1;
    @(posedge clk); #1;
    AluOutM = v.addr; StoreDataM = v.sdata; MemWriteM = v.we;
    MemToRegM = v.ld; RegWriteM = v.lt;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
    o_stall = 0; o_lv = 0; o_exc = 0; o_req = 0; o_done = 1'b0;
    o_addr = 32'h0; o_we = 4'h0; o_wdata = 32'h0;
    for (int c = 0; c < 64 && !o_done; c++) begin
      @(negedge clk);
      bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
      if (LoadValidM)  o_lv++;
      if (MisalignExc) o_exc++;
      if (!MemStall) begin
        o_done  = 1'b1;
        o_ldata = LoadDataM;
      end else begin
        o_stall++;
        if (bus.bus_req) begin
          if (o_req == v.gd) begin
            bus.bus_gnt = 1'b1; gnt_at = c;
            o_addr = bus.bus_addr; o_we = bus.bus_we; o_wdata = bus.bus_wdata;
          end else if (v.spur) begin
            bus.bus_rvalid = 1'b1; bus.bus_rdata = ~v.rdata;
          end
          o_req++;
        end else if (gnt_at >= 0 && c == gnt_at + 1 + v.rd) begin
          bus.bus_rvalid = 1'b1; bus.bus_rdata = v.rdata;
        end
      end
    end
    @(posedge clk); #1;
    MemWriteM = 4'h0; MemToRegM = 1'b0; RegWriteM = LT_NONE;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (LoadValidM)  o_lv++;
      if (MisalignExc) o_exc++;
    end
  endtask

  task automatic run_check(input vec_t v, input string tag);
    logic [31:0] exp_ld;
    run(v);
    exp_ld = v.ld ? v.e_ld : last_ld;
    chk({tag, ".done"},    32'(o_done), 32'd1);
    chk({tag, ".stall"},   32'(o_stall), 32'(v.e_stall));
    chk({tag, ".req"},     32'(o_req), 32'(v.gd + 1));
    chk({tag, ".lvalid"},  32'(o_lv), 32'(v.ld));
    chk({tag, ".exc"},     32'(o_exc), 32'd0);
    chk({tag, ".addr"},    o_addr, v.e_addr);
    chk({tag, ".we"},      32'(o_we), 32'(v.e_we));
    chk({tag, ".wdata"},   o_wdata, v.e_wdata);
    chk({tag, ".ldata"},   o_ldata, exp_ld);
    chk({tag, ".hold"},    LoadDataM, exp_ld);
    last_ld = exp_ld;
  endtask

  vec_t tbl[9];

  initial begin
    rst_n = 1'b0;
    AluOutM = '0; StoreDataM = '0; MemWriteM = '0; MemToRegM = 1'b0; RegWriteM = LT_NONE;
    bus.bus_gnt = 1'b0; bus.bus_rvalid = 1'b0; bus.bus_rdata = '0;

    //            addr        sdata       we     ld  lt       gd rd rdata        spur  e_addr      e_we   e_wdata     e_ld        stall
    tbl[0] = '{32'h100, 32'hDEADBEEF, 4'hF, 1'b0, LT_NONE, 0, 0, 32'h0,        1'b0, 32'h100, 4'hF, 32'hDEADBEEF, 32'h0,        2};
    tbl[1] = '{32'h103, 32'h000000A5, 4'h1, 1'b0, LT_NONE, 0, 0, 32'h0,        1'b0, 32'h100, 4'h8, 32'hA5000000, 32'h0,        2};
    tbl[2] = '{32'h102, 32'hFFFFFFFF, 4'h0, 1'b1, LB,      0, 0, 32'h0080FF00, 1'b0, 32'h100, 4'h0, 32'h0,        32'hFFFFFF80, 3};
    tbl[3] = '{32'h102, 32'hFFFFFFFF, 4'h0, 1'b1, LBU,     0, 0, 32'h0080FF00, 1'b0, 32'h100, 4'h0, 32'h0,        32'h00000080, 3};
    tbl[4] = '{32'h200, 32'h0,        4'h0, 1'b1, LW,      3, 1, 32'h12345678, 1'b1, 32'h200, 4'h0, 32'h0,        32'h12345678, 7};
    tbl[5] = '{32'h102, 32'h0,        4'h0, 1'b1, LH,      0, 0, 32'h80010000, 1'b0, 32'h100, 4'h0, 32'h0,        32'hFFFF8001, 3};
    tbl[6] = '{32'h106, 32'h0,        4'h0, 1'b1, LHU,     0, 0, 32'h80010000, 1'b0, 32'h104, 4'h0, 32'h0,        32'h00008001, 3};
    tbl[7] = '{32'h20A, 32'h0000BEEF, 4'h3, 1'b0, LT_NONE, 1, 0, 32'h0,        1'b0, 32'h208, 4'hC, 32'hBEEF0000, 32'h0,        3};
    tbl[8] = '{32'h001, 32'h0,        4'h0, 1'b1, LB,      2, 2, 32'h00007F00, 1'b1, 32'h000, 4'h0, 32'h0,        32'h0000007F, 7};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst.state",  32'(dut.state_q), 32'(IDLE));
    chk("rst.req",    32'(bus.bus_req), 32'd0);
    chk("rst.lvalid", 32'(LoadValidM), 32'd0);
    chk("rst.exc",    32'(MisalignExc), 32'd0);
    chk("rst.ldata",  LoadDataM, 32'd0);
    rst_n = 1'b1;

    for (int i = 0; i < 9; i++) run_check(tbl[i], $sformatf("vec%0d", i));

    // Randomized accesses against the reference model
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      int   kind = int'($urandom_range(0, 7));
      int   off;
      v.addr  = $urandom;
      v.sdata = $urandom;
      v.rdata = $urandom;
      v.gd    = int'($urandom_range(0, 3));
      v.rd    = int'($urandom_range(0, 3));
      v.spur  = 1'($urandom_range(0, 1));
      v.ld    = (kind >= 3);
      v.we    = (kind == 0) ? BE_BYTE : (kind == 1) ? BE_HALF : (kind == 2) ? BE_WORD : BE_NONE;
      v.lt    = (kind == 3) ? LB : (kind == 4) ? LH : (kind == 5) ? LW :
                (kind == 6) ? LBU : (kind == 7) ? LHU : LT_NONE;
`ifdef MEM_MISALIGN_TRAP_EN
      if (kind == 1 || kind == 4 || kind == 7) v.addr[0] = 1'b0;
      if (kind == 2 || kind == 5) v.addr[1:0] = 2'b00;
`endif
      off       = int'(v.addr % 4);
      v.e_addr  = v.addr - 32'(off);
      v.e_we    = v.ld ? 4'h0 : ref_we(v.we, off);
      v.e_wdata = v.ld ? 32'h0 : ref_wdata(v.sdata, off);
      v.e_ld    = ref_load(v.rdata, off, v.lt);
      v.e_stall = 1 + (v.gd + 1) + (v.ld ? v.rd + 1 : 0);
      run_check(v, $sformatf("rnd%0d", n));
    end

    // Reset while waiting for read data: transaction is abandoned, late rvalid ignored
    begin
      int lv = 0;
      @(posedge clk); #1;
      AluOutM = 32'h300; MemToRegM = 1'b1; RegWriteM = LW; MemWriteM = 4'h0;
      @(negedge clk);
      @(negedge clk);
      chk("mrst.req_before", 32'(bus.bus_req), 32'd1);
      bus.bus_gnt = 1'b1;
      @(posedge clk); #1;
      bus.bus_gnt = 1'b0;
      @(negedge clk);
      chk("mrst.in_wait", 32'(dut.state_q), 32'(WAIT));
      rst_n = 1'b0;
      #1;
      chk("mrst.req_drop", 32'(bus.bus_req), 32'd0);
      chk("mrst.state",    32'(dut.state_q), 32'(IDLE));
      MemToRegM = 1'b0; RegWriteM = LT_NONE;
      @(negedge clk);
      rst_n = 1'b1;
      bus.bus_rvalid = 1'b1; bus.bus_rdata = 32'hCAFEF00D;
      @(negedge clk);
      bus.bus_rvalid = 1'b0;
      if (LoadValidM) lv++;
      repeat (2) begin
        @(negedge clk);
        if (LoadValidM) lv++;
      end
      chk("mrst.lvalid_cnt", 32'(lv), 32'd0);
      chk("mrst.state_end",  32'(dut.state_q), 32'(IDLE));
      chk("mrst.ldata",      LoadDataM, 32'd0);
      last_ld = 32'd0;
    end

`ifdef MEM_MISALIGN_TRAP_EN
    // Misaligned word load traps without touching the bus
    begin
      vec_t v;
      v = '{32'h102, 32'h0, 4'h0, 1'b1, LW, 0, 0, 32'h11223344, 1'b0,
            32'h100, 4'h0, 32'h0, 32'h0, 1};
      run(v);
      chk("trap.done",   32'(o_done), 32'd1);
      chk("trap.req",    32'(o_req), 32'd0);
      chk("trap.stall",  32'(o_stall), 32'd1);
      chk("trap.exc",    32'(o_exc), 32'd1);
      chk("trap.lvalid", 32'(o_lv), 32'd0);
      chk("trap.ldata",  LoadDataM, last_ld);
    end
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
